fetch_rotated_pixel: RTL and testbench

- Consumer end of the pixel-address FIFO filled by the rotation address generator. Pops one {y,x} source coordinate at a time and range-checks it against the source frame.
- In-range coordinates become linear word reads on the frame-buffer read port. Out-of-range coordinates become BLACK fill pixels.
- Emits the resulting rotated pixel stream strictly in address order, toward the output pixel FIFO, with an end-of-frame marker.

---
 rtl/fetch_rotated_pixel.sv | 166 ++++++++++++++++
 tb/tb_fetch_rotated_pixel.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_rotated_pixel.sv
// Pops {y,x} source coordinates, range-checks them, issues in-range frame-buffer
// reads and emits the rotated pixel stream in coordinate order with BLACK fill.
module fetch_rotated_pixel #(
    parameter int               H_ACTIVE = 1280,
    parameter int               V_ACTIVE = 720,
    parameter int               ADDR_W   = 11,
    parameter int               MEM_AW   = 21,
    parameter int               PIX_W    = 16,
    parameter int               MAX_OUT  = 8,
    parameter logic [PIX_W-1:0] BLACK    = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                addr_fifo_empty,
    output logic                addr_fifo_rd_en,
    input  logic [2*ADDR_W-1:0] addr_fifo_dout,
    input  logic                pix_fifo_full,
    output logic                rd_req,
    output logic [MEM_AW-1:0]   rd_addr,
    input  logic                rd_ack,
    input  logic                rd_data_valid,
    input  logic [PIX_W-1:0]    rd_data,
    output logic                pix_valid,
    output logic [PIX_W-1:0]    pix_data,
    output logic                pix_last,
    output logic                ovf_err
);
    localparam int                CW       = $clog2(MAX_OUT);
    localparam logic [CW:0]       TAG_MAX  = (CW+1)'(MAX_OUT);
    localparam logic [ADDR_W:0]   LIM_X    = (ADDR_W+1)'(H_ACTIVE);
    localparam logic [ADDR_W:0]   LIM_Y    = (ADDR_W+1)'(V_ACTIVE);
    localparam logic [MEM_AW-1:0] LAST_IDX = MEM_AW'(H_ACTIVE*V_ACTIVE-1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_REQ   = 2'd3;

    logic [1:0]        r_state;
    logic              r_rd_en, r_rd_req, r_pix_valid, r_pix_last, r_ovf;
    logic [MEM_AW-1:0] r_rd_addr, r_pix_cnt;
    logic [PIX_W-1:0]  r_pix_data;
    logic [MAX_OUT-1:0] r_tag_mem;
    logic [CW:0]       r_tag_wp, r_tag_rp, r_tag_cnt, r_rsp_wp, r_rsp_rp;
    logic [PIX_W-1:0]  r_rsp_mem [MAX_OUT];

    // rd_en is registered, so the popped word is on dout while in S_CHECK
    logic [ADDR_W-1:0] w_x, w_y;
    logic              w_in_range, w_tag_push, w_tag_empty, w_tag_head;
    logic              w_rsp_empty, w_rsp_full, w_emit_black, w_emit_fetch;
    logic              w_bypass, w_tag_pop, w_rsp_pop, w_rsp_push, w_rsp_drop;
    logic [MEM_AW-1:0] w_lin;
    logic [PIX_W-1:0]  w_rsp_head;

    assign w_x        = addr_fifo_dout[ADDR_W-1:0];
    assign w_y        = addr_fifo_dout[2*ADDR_W-1:ADDR_W];
    assign w_in_range = ({1'b0, w_x} < LIM_X) && ({1'b0, w_y} < LIM_Y);
    assign w_lin      = MEM_AW'(w_y) * MEM_AW'(H_ACTIVE) + MEM_AW'(w_x);
    assign w_tag_push = (r_state == S_CHECK);

    assign w_tag_empty = (r_tag_wp == r_tag_rp);
    assign w_tag_head  = r_tag_mem[r_tag_rp[CW-1:0]];
    assign w_rsp_empty = (r_rsp_wp == r_rsp_rp);
    assign w_rsp_full  = ((r_rsp_wp ^ r_rsp_rp) == {1'b1, {CW{1'b0}}});
    assign w_rsp_head  = r_rsp_mem[r_rsp_rp[CW-1:0]];

    // A response for the head tag skips the FIFO when nothing is queued ahead of it
    assign w_emit_black = !w_tag_empty && !w_tag_head;
    assign w_emit_fetch = !w_tag_empty && w_tag_head && (!w_rsp_empty || rd_data_valid);
    assign w_bypass     = w_emit_fetch && w_rsp_empty;
    assign w_tag_pop    = w_emit_black || w_emit_fetch;
    assign w_rsp_pop    = w_emit_fetch && !w_rsp_empty;
    assign w_rsp_push   = rd_data_valid && !w_bypass && !w_rsp_full;
    assign w_rsp_drop   = rd_data_valid && !w_bypass && w_rsp_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_en   <= 1'b0;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!addr_fifo_empty && (r_tag_cnt < TAG_MAX) && !pix_fifo_full) begin
                        r_rd_en <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_in_range) begin
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= w_lin;
                        r_state   <= S_REQ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    if (rd_ack) begin
                        r_rd_req <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_mem <= '0;
            r_tag_wp  <= '0;
            r_tag_rp  <= '0;
            r_tag_cnt <= '0;
            r_rsp_wp  <= '0;
            r_rsp_rp  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_tag_push) begin
                r_tag_mem[r_tag_wp[CW-1:0]] <= w_in_range;
                r_tag_wp <= r_tag_wp + 1'b1;
            end
            if (w_tag_pop) r_tag_rp <= r_tag_rp + 1'b1;
            case ({w_tag_push, w_tag_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
                2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
                default: r_tag_cnt <= r_tag_cnt;
            endcase
            if (w_rsp_push) r_rsp_wp <= r_rsp_wp + 1'b1;
            if (w_rsp_pop)  r_rsp_rp <= r_rsp_rp + 1'b1;
            if (w_rsp_drop) r_ovf    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_push) r_rsp_mem[r_rsp_wp[CW-1:0]] <= rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_pix_last  <= 1'b0;
            r_pix_cnt   <= '0;
        end else begin
            r_pix_valid <= w_tag_pop;
            r_pix_last  <= w_tag_pop && (r_pix_cnt == LAST_IDX);
            if (w_tag_pop) begin
                r_pix_data <= w_emit_black ? BLACK : (w_bypass ? rd_data : w_rsp_head);
                r_pix_cnt  <= (r_pix_cnt == LAST_IDX) ? '0 : r_pix_cnt + 1'b1;
            end
        end
    end

    assign addr_fifo_rd_en = r_rd_en;
    assign rd_req          = r_rd_req;
    assign rd_addr         = r_rd_addr;
    assign pix_valid       = r_pix_valid;
    assign pix_data        = r_pix_data;
    assign pix_last        = r_pix_last;
    assign ovf_err         = r_ovf;
endmodule

// File: tb/tb_fetch_rotated_pixel.sv
// Randomized bench for fetch_rotated_pixel: address-FIFO and memory models plus
// an in-order scoreboard of expected pixels derived from the coordinates fed.
module tb_fetch_rotated_pixel;
    localparam int H = 8, V = 4, AW = 11, MAW = 21, PW = 16, MO = 8;
    localparam logic [PW-1:0] BLK = 16'hBEEF;

    logic            clk = 1'b0, rst = 1'b1;
    logic            addr_fifo_empty = 1'b1, addr_fifo_rd_en;
    logic [2*AW-1:0] addr_fifo_dout = '0;
    logic            pix_fifo_full = 1'b0;
    logic            rd_req, rd_ack = 1'b0, rd_data_valid = 1'b0;
    logic [MAW-1:0]  rd_addr;
    logic [PW-1:0]   rd_data = '0, pix_data;
    logic            pix_valid, pix_last, ovf_err;

    always #5 clk = ~clk;

    fetch_rotated_pixel #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .MEM_AW(MAW),
                          .PIX_W(PW), .MAX_OUT(MO), .BLACK(BLK)) dut (
        .clk(clk), .rst(rst), .addr_fifo_empty(addr_fifo_empty),
        .addr_fifo_rd_en(addr_fifo_rd_en), .addr_fifo_dout(addr_fifo_dout),
        .pix_fifo_full(pix_fifo_full), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
        .ovf_err(ovf_err));

    typedef struct { int due; logic [PW-1:0] d; } mrd_t;

    int n_cmp = 0, n_bad = 0;
    logic [2*AW-1:0] afq[$];
    logic [PW-1:0]   expq[$];
    mrd_t            mq[$];
    int cyc = 0, lat_min = 4, lat_max = 4, ack_max = 0, ack_wait = 0;
    int n_pop = 0, n_pix = 0, n_reqcyc = 0, n_ack = 0, fcnt = 0;
    bit dstall = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Reference: a coordinate yields y*H+x if on-frame, BLACK otherwise, in pop order
    always @(negedge clk) begin
        logic [2*AW-1:0] c;
        int x, y;
        cyc++;
        if (rst) begin
            afq.delete(); expq.delete(); mq.delete();
            rd_ack = 1'b0; rd_data_valid = 1'b0; addr_fifo_empty = 1'b1;
            fcnt = 0; ack_wait = 0;
        end else begin
            if (pix_valid) begin
                n_pix++;
                if (expq.size() == 0) chk("extra_pix", 1, 0);
                else begin
                    chk("pix_data", pix_data, expq.pop_front());
                    chk("pix_last", pix_last, (fcnt == H*V-1));
                    fcnt = (fcnt + 1) % (H*V);
                end
            end
            if (addr_fifo_rd_en) begin
                n_pop++;
                if (afq.size() == 0) chk("pop_empty", 1, 0);
                else begin
                    c = afq.pop_front();
                    addr_fifo_dout = c;
                    x = int'(c[AW-1:0]);
                    y = int'(c[2*AW-1:AW]);
                    expq.push_back((x < H && y < V) ? PW'(y*H + x) : BLK);
                end
            end
            addr_fifo_empty = (afq.size() == 0);
            if (rd_req) n_reqcyc++;
            if (rd_ack) rd_ack = 1'b0;
            else if (rd_req) begin
                if (ack_wait > 0) ack_wait--;
                else begin
                    rd_ack = 1'b1;
                    n_ack++;
                    mq.push_back('{cyc + $urandom_range(lat_max, lat_min), rd_addr[PW-1:0]});
                    ack_wait = $urandom_range(ack_max, 0);
                end
            end
            rd_data_valid = 1'b0;
            if (!dstall && mq.size() > 0 && mq[0].due <= cyc) begin
                rd_data_valid = 1'b1;
                rd_data = mq[0].d;
                mq.delete(0);
            end
        end
    end

    task automatic push(input int x, input int y);
        logic [AW-1:0] xs, ys;
        xs = AW'(x);
        ys = AW'(y);
        afq.push_back({ys, xs});
    endtask

    task automatic drain(input string tag, input int budget);
        int t = 0;
        while ((afq.size() > 0 || expq.size() > 0 || mq.size() > 0) && t < budget) begin
            @(negedge clk); t++;
        end
        chk(tag, (t < budget), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic frame();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) push(x, y);
    endtask

    initial begin
        int b0, b1, t;
        bit stable;
        logic [MAW-1:0] a0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", addr_fifo_rd_en, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_pix_last", pix_last, 0);
        chk("rst_ovf", ovf_err, 0);
        rst = 1'b0;

        // Full raster frame, data = address
        b0 = n_pix;
        frame();
        drain("frame_drain", 2000);
        chk("frame_count", n_pix - b0, 32);

        // Off-frame only: no reads, BLACK after 3 cycles
        b0 = n_reqcyc; b1 = n_pix;
        push(8, 0); push(0, 4); push(2047, 2047);
        t = 0;
        while (!addr_fifo_rd_en && t < 50) begin @(negedge clk); t++; end
        t = 0;
        while (!pix_valid && t < 50) begin @(negedge clk); t++; end
        chk("black_latency", t, 3);
        drain("oor_drain", 200);
        chk("oor_no_req", n_reqcyc - b0, 0);
        chk("oor_count", n_pix - b1, 3);

        // BLACK queued behind a slow fetch
        lat_min = 10; lat_max = 10; b0 = n_pix;
        push(3, 1); push(9, 0); push(0, 2);
        drain("mix_drain", 300);
        chk("mix_count", n_pix - b0, 3);

        // Ack held off for 20 cycles
        lat_min = 2; lat_max = 2; ack_wait = 20; b0 = n_ack;
        push(1, 0); push(2, 0);
        t = 0;
        while (!rd_req && t < 50) begin @(negedge clk); t++; end
        a0 = rd_addr; stable = 1'b1; b1 = 0;
        repeat (19) begin
            @(negedge clk);
            if (!rd_req || rd_addr != a0) stable = 1'b0;
            if (addr_fifo_rd_en) b1++;
        end
        chk("hold_addr", a0, 1);
        chk("hold_stable", stable, 1);
        chk("hold_no_pop", b1, 0);
        drain("hold_drain", 300);
        chk("hold_acks", n_ack - b0, 2);

        // Stalled responses: only MAX_OUT coordinates go in flight
        dstall = 1'b1; b0 = n_pop; b1 = n_pix;
        for (int i = 0; i < 20; i++) push(i % H, (i / H) % V);
        repeat (100) @(negedge clk);
        chk("stall_pops", n_pop - b0, MO);
        chk("stall_no_pix", n_pix - b1, 0);
        dstall = 1'b0;
        drain("stall_drain", 1000);
        chk("stall_count", n_pix - b1, 20);

        // Downstream full: pops halt, in-flight pixels still drain
        for (int i = 0; i < 20; i++) push(H - 1 - (i % H), i % V);
        repeat (12) @(negedge clk);
        pix_fifo_full = 1'b1;
        repeat (2) @(negedge clk);
        b0 = n_pop;
        repeat (60) @(negedge clk);
        chk("full_no_pop", n_pop - b0, 0);
        chk("full_inflight_drained", expq.size(), 0);
        pix_fifo_full = 1'b0;
        drain("full_drain", 1000);

        // Reset mid-frame, then a clean frame must end on its 32nd pixel
        for (int i = 0; i < 10; i++) push(i % H, 1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_rd_en", addr_fifo_rd_en, 0);
        chk("mrst_rd_req", rd_req, 0);
        chk("mrst_rd_addr", rd_addr, 0);
        chk("mrst_pix_valid", pix_valid, 0);
        chk("mrst_pix_data", pix_data, 0);
        chk("mrst_pix_last", pix_last, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b0 = n_pix;
        frame();
        drain("mrst_drain", 2000);
        chk("mrst_count", n_pix - b0, 32);

        // Random mix with random latency, ack delay, backpressure and stalls
        lat_min = 1; lat_max = 8; ack_max = 3; b0 = n_pix;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(3, 0) != 0) push($urandom_range(H-1, 0), $urandom_range(V-1, 0));
            else push($urandom_range(2047, 0), $urandom_range(2047, 0));
            repeat ($urandom_range(4, 0)) begin
                @(negedge clk);
                pix_fifo_full = ($urandom_range(7, 0) == 0);
                dstall = ($urandom_range(5, 0) == 0);
            end
        end
        pix_fifo_full = 1'b0; dstall = 1'b0;
        drain("rand_drain", 20000);
        chk("rand_count", n_pix - b0, 150);
        chk("ovf_err", ovf_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
